// File: rtl/dot_product_pipelined.sv
// Pipelined 3-element unsigned dot product (multiply stage, then sum stage).
// Latency is two enabled edges; enable low stalls every stage, and the sum wraps modulo 2^RES_W.
module dot_product_pipelined #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    output logic [RES_W-1:0]  result,
    output logic              result_valid
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 2;

    logic [PROD_W-1:0] p0_q, p1_q, p2_q;
    logic [PROD_W-1:0] p0_d, p1_d, p2_d;
    logic              v1_q, v1_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              res_vld_q, res_vld_d;
    logic [SUM_W-1:0]  sum_full;

    // Two guard bits keep the three-way sum exact before it is wrapped to RES_W.
    assign sum_full = SUM_W'(p0_q) + SUM_W'(p1_q) + SUM_W'(p2_q);

    always_comb begin
        p0_d      = p0_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        v1_d      = v1_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        if (enable) begin
            p0_d      = PROD_W'(a0) * PROD_W'(b0);
            p1_d      = PROD_W'(a1) * PROD_W'(b1);
            p2_d      = PROD_W'(a2) * PROD_W'(b2);
            v1_d      = 1'b1;
            res_d     = RES_W'(sum_full);
            res_vld_d = v1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_q      <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            v1_q      <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            v1_q      <= v1_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign result       = res_q;
    assign result_valid = res_vld_q;

endmodule

// File: tb/tb_dot_product_pipelined.sv
// Directed-vector bench for dot_product_pipelined with hand-computed expected results.
module tb_dot_product_pipelined;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  a0, a1, a2, b0, b1, b2;
    logic [15:0] result;
    logic        result_valid;

    int total = 0;
    int bad   = 0;

    dot_product_pipelined #(.DATA_W(8), .RES_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .a0           (a0),
        .a1           (a1),
        .a2           (a2),
        .b0           (b0),
        .b1           (b1),
        .b2           (b2),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int x0, input int x1, input int x2,
                           input int y0, input int y1, input int y2);
        a0 = 8'(x0); a1 = 8'(x1); a2 = 8'(x2);
        b0 = 8'(y0); b1 = 8'(y1); b2 = 8'(y2);
    endtask

    // Advance one clock; outputs are then sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("rst_pulse_res", int'(result), 0);
        chk("rst_pulse_vld", int'(result_valid), 0);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        set_ops(5, 6, 7, 8, 9, 10);

        // Reset held with live operands and enable high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_res", int'(result), 0);
            chk("reset_vld", int'(result_valid), 0);
        end
        reset = 1'b1;

        // Basic: 1*9 + 2*6 + 3*3 = 30
        set_ops(1, 2, 3, 9, 6, 3);
        step();
        chk("basic_vld_edge1", int'(result_valid), 0);
        step();
        chk("basic_res", int'(result), 30);
        chk("basic_vld", int'(result_valid), 1);

        // Stall after the first stage
        pulse_reset();
        step();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_res", int'(result), 0);
            chk("stall_vld", int'(result_valid), 0);
        end
        enable = 1'b1;
        step();
        chk("stall_resume_res", int'(result), 30);
        chk("stall_resume_vld", int'(result_valid), 1);

        // Streaming: 30, 15, 0 on consecutive edges
        set_ops(1, 2, 3, 9, 6, 3);
        step();
        set_ops(4, 5, 6, 1, 1, 1);
        step();
        chk("stream_0", int'(result), 30);
        set_ops(0, 0, 0, 7, 7, 7);
        step();
        chk("stream_1", int'(result), 15);
        set_ops(2, 2, 2, 2, 2, 2);
        step();
        chk("stream_2", int'(result), 0);
        step();
        chk("stream_3", int'(result), 12);

        // Overflow: 3*255*255 = 195075, mod 65536 = 64003
        set_ops(255, 255, 255, 255, 255, 255);
        step();
        step();
        chk("overflow_res", int'(result), 64003);

        // Disabled cycles ignore new operands and hold the result
        enable = 1'b0;
        set_ops(1, 1, 1, 1, 1, 1);
        step();
        step();
        chk("hold_res", int'(result), 64003);
        chk("hold_vld", int'(result_valid), 1);
        enable = 1'b1;
        step();
        chk("hold_release_res", int'(result), 64003);
        step();
        chk("after_hold_res", int'(result), 3);

        // Reset between the stage-1 and stage-2 edges
        set_ops(1, 2, 3, 9, 6, 3);
        step();
        reset = 1'b0;
        #1;
        chk("midrst_res", int'(result), 0);
        chk("midrst_vld", int'(result_valid), 0);
        reset = 1'b1;
        step();
        chk("midrst_edge1_res", int'(result), 0);
        chk("midrst_edge1_vld", int'(result_valid), 0);
        step();
        chk("midrst_edge2_res", int'(result), 30);
        chk("midrst_edge2_vld", int'(result_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_pipelined.md
Name: dot_product_pipelined

Overview:
- Pipelined 3-element dot product of two unsigned vectors: result = a0*b0 + a1*b1 + a2*b2.
- Arithmetic building block for the parametrized matrix multiplier; one instance computes one row-by-column element.
- Two register stages (multiply, then sum). A single enable advances the whole pipeline, so enable acts as a global stall when low.

Parameters:
- DATA_W, 8, width of each unsigned operand a0..a2, b0..b2.
- RES_W, 16, width of result. The sum is truncated modulo 2^RES_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  pipeline advance; when 0, all pipeline registers hold
- a0  input  DATA_W  vector A element 0, unsigned
- a1  input  DATA_W  vector A element 1, unsigned
- a2  input  DATA_W  vector A element 2, unsigned
- b0  input  DATA_W  vector B element 0, unsigned
- b1  input  DATA_W  vector B element 1, unsigned
- b2  input  DATA_W  vector B element 2, unsigned
- result  output  RES_W  registered dot product
- result_valid  output  1  result holds a completed dot product; may be left unconnected

Behaviour:
- Reset (reset=0, asynchronous):
  - Stage-1 product registers p0..p2 clear to 0; v1 clears to 0.
  - result clears to 0; result_valid clears to 0.
  - Reset dominates enable and clk.
- Stage 1, on a rising clk with enable=1:
  - p0<=a0*b0, p1<=a1*b1, p2<=a2*b2, each a full 2*DATA_W-bit unsigned product.
  - v1<=1.
- Stage 2, on the same edge with enable=1:
  - result <= (p0+p1+p2) mod 2^RES_W. The sum uses the previous p values.
  - result_valid<=v1.
- enable=0: every register (p0..p2, v1, result, result_valid) holds its value. Inputs are ignored.
- Latency: the result for operands sampled at enabled edge N appears after enabled edge N+1. That is two enabled edges; disabled cycles in between do not count.
- Throughput: one new operand set per enabled cycle, fully pipelined.
- result_valid is 0 after reset until the second enabled edge, then stays 1 until the next reset.
- Overflow: worst case is 3*(2^DATA_W-1)^2. With defaults, 195075 exceeds 16 bits, so result wraps mod 65536. No saturation and no overflow flag.
- Reset mid-operation: in-flight products are discarded and result returns to 0. The next valid result requires two enabled edges after reset deasserts.
- Operands must be stable around the sampling edge only; there is no input holding requirement.
- No combinational path from inputs to result.

Test Plan:
- Reset: hold reset=0 for 2 cycles with nonzero inputs and enable=1 -> result=0, result_valid=0 throughout.
- Basic: a=(1,2,3), b=(9,6,3), enable=1 for 2 edges -> result=30 and result_valid=1 after the 2nd edge.
- Stall: same operands, enable=1 for 1 edge, then enable=0 for 4 cycles -> result stays 0 and result_valid stays 0. Re-assert enable -> result=30 one edge later.
- Streaming: operand sets (1,2,3)·(9,6,3), then (4,5,6)·(1,1,1), then (0,0,0)·(7,7,7) on consecutive enabled edges -> result 30, 15, 0 on consecutive edges.
- Overflow: all operands 255 -> result=64003 (195075 mod 65536).
- Mid-operation reset: assert reset=0 between the stage-1 and stage-2 edges -> result=0, result_valid=0. After release, a fresh result needs 2 enabled edges.
